piped_write_burst_queue: RTL and testbench

Write-side companion to the core's piped read queue: buffers 32-bit words pushed by a RISC core and drains them to the memory/ring side as fixed-length bursts. Words accumulate in a distributed-RAM FIFO. Once a full burst is present, the block requests the downstream port. After the grant it streams BURST words back-to-back through a registered output stage (dout), with no read bypass needed.

---
 rtl/piped_write_burst_queue_pkg.sv | 27 ++
 rtl/wbq_ram.sv | 30 +++
 rtl/piped_write_burst_queue.sv | 142 ++++++++++++++
 tb/tb_piped_write_burst_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/piped_write_burst_queue_pkg.sv
// Shared definitions for the piped write burst queue.
//   - wbq_state_e : drain-side state machine (IDLE -> WAIT -> STREAM)
//   - WBQ_*       : default word width, queue depth (log2) and burst length
//   - wbq_burst_ok: legality check on burst length vs. queue depth
package piped_write_burst_queue_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STREAM = 2'd2
   } wbq_state_e;

   localparam int unsigned WBQ_WIDTH      = 32;
   localparam int unsigned WBQ_DEPTH_LOG2 = 6;
   localparam int unsigned WBQ_BURST      = 8;

   // A burst must be a power of two, at least 2, and no more than half the queue.
   function automatic bit wbq_burst_ok(input int unsigned burst,
                                       input int unsigned depth_log2);
      return (burst >= 2) &&
             ((burst & (burst - 1)) == 0) &&
             (burst <= ((32'd1 << depth_log2) / 2));
   endfunction

   localparam bit WBQ_DEFAULTS_OK = wbq_burst_ok(WBQ_BURST, WBQ_DEPTH_LOG2);

endpackage

// File: rtl/wbq_ram.sv
// DEPTH x WIDTH distributed RAM: synchronous write, asynchronous read.
//   clk : write clock
//   we  : write enable
//   wa  : write address
//   din : write data
//   ra  : read address
//   q   : read data (combinational from ra)
module wbq_ram #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    ra,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= din;
      end
   end

   assign q = mem[ra];

endmodule

// File: rtl/piped_write_burst_queue.sv
// Write burst queue: buffers words pushed by the core and drains them
// downstream as fixed-length bursts through a registered output stage.
//   clk, rst          : clock, synchronous active-high reset
//   din, wr_en        : push interface from the core
//   full, almost_full : level == DEPTH, level >= DEPTH - BURST
//   overflow          : sticky, a push was attempted while full
//   level             : words currently held
//   burst_req/ack     : request held until downstream grants the burst
//   dout, dout_valid  : registered burst beats, BURST consecutive cycles
//   burst_start       : marks the first beat of each burst
module piped_write_burst_queue
   import piped_write_burst_queue_pkg::*;
#(
   parameter int unsigned WIDTH      = WBQ_WIDTH,
   parameter int unsigned DEPTH_LOG2 = WBQ_DEPTH_LOG2,
   parameter int unsigned BURST      = WBQ_BURST
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    din,
   input  logic                wr_en,
   output logic                full,
   output logic                almost_full,
   output logic                overflow,
   output logic [DEPTH_LOG2:0] level,
   output logic                burst_req,
   input  logic                burst_ack,
   output logic [WIDTH-1:0]    dout,
   output logic                dout_valid,
   output logic                burst_start
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned BW    = $clog2(BURST) + 1;
   localparam int unsigned AF    = DEPTH - BURST;

   localparam logic [DEPTH_LOG2:0] LVL_FULL  = DEPTH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0] LVL_AF    = AF[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0] LVL_BURST = BURST[DEPTH_LOG2:0];
   localparam logic [BW-1:0]       BEAT_LAST = BURST[BW-1:0];
   localparam logic [BW-1:0]       BEAT_ONE  = {{(BW-1){1'b0}}, 1'b1};

   if (!WBQ_DEFAULTS_OK || !wbq_burst_ok(BURST, DEPTH_LOG2)) begin : g_bad_burst
      $error("BURST must be a power of 2 with 2 <= BURST <= DEPTH/2");
   end

   wbq_state_e          state_q;
   logic [DEPTH_LOG2:0] wa_q, wa_d, ra_q, ra_d, level_q;
   logic [BW-1:0]       beat_q;
   logic [WIDTH-1:0]    dout_q, ram_q;
   logic                dout_valid_q, burst_start_q, burst_req_q, overflow_q;
   logic                wr_ok, rd_adv;

   assign full        = (level_q == LVL_FULL);
   assign almost_full = (level_q >= LVL_AF);
   assign wr_ok       = wr_en & ~full;

   // The read pointer advances on the grant and on every streaming beat
   // except the closing one, giving exactly BURST reads per burst.
   assign rd_adv = ((state_q == WAIT) & burst_ack) |
                   ((state_q == STREAM) & (beat_q != BEAT_LAST));

   always_comb begin
      wa_d = wa_q + {{DEPTH_LOG2{1'b0}}, wr_ok};
      ra_d = ra_q + {{DEPTH_LOG2{1'b0}}, rd_adv};
   end

   wbq_ram #(
      .WIDTH (WIDTH),
      .AW    (DEPTH_LOG2)
   ) u_ram (
      .clk (clk),
      .we  (wr_ok),
      .wa  (wa_q[DEPTH_LOG2-1:0]),
      .din (din),
      .ra  (ra_q[DEPTH_LOG2-1:0]),
      .q   (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wa_q       <= '0;
         ra_q       <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wa_q       <= wa_d;
         ra_q       <= ra_d;
         level_q    <= wa_d - ra_d;
         overflow_q <= overflow_q | (wr_en & full);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         beat_q        <= '0;
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
         burst_start_q <= 1'b0;
         burst_req_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (level_q >= LVL_BURST) begin
                  state_q     <= WAIT;
                  burst_req_q <= 1'b1;
               end
            end
            WAIT: begin
               if (burst_ack) begin
                  dout_q        <= ram_q;
                  beat_q        <= BEAT_ONE;
                  dout_valid_q  <= 1'b1;
                  burst_start_q <= 1'b1;
                  burst_req_q   <= 1'b0;
                  state_q       <= STREAM;
               end
            end
            STREAM: begin
               burst_start_q <= 1'b0;
               if (beat_q == BEAT_LAST) begin
                  dout_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end else begin
                  dout_q <= ram_q;
                  beat_q <= beat_q + BEAT_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign overflow    = overflow_q;
   assign level       = level_q;
   assign burst_req   = burst_req_q;
   assign dout        = dout_q;
   assign dout_valid  = dout_valid_q;
   assign burst_start = burst_start_q;

endmodule

// File: tb/tb_piped_write_burst_queue.sv
// Self-checking bench for piped_write_burst_queue: a word-queue reference
// model tracks contents, level, flags and the expected burst beats.
module tb_piped_write_burst_queue;

   localparam int DEPTH = 64;
   localparam int BURST = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] din;
   logic        wr_en;
   logic        full, almost_full, overflow;
   logic [6:0]  level;
   logic        burst_req;
   logic        burst_ack;
   logic [31:0] dout;
   logic        dout_valid, burst_start;

   piped_write_burst_queue #(
      .WIDTH      (32),
      .DEPTH_LOG2 (6),
      .BURST      (BURST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .wr_en       (wr_en),
      .full        (full),
      .almost_full (almost_full),
      .overflow    (overflow),
      .level       (level),
      .burst_req   (burst_req),
      .burst_ack   (burst_ack),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .burst_start (burst_start)
   );

   always #5 clk = ~clk;

   // reference model
   logic [31:0] mq[$];
   logic        m_ovf;
   int          rem;
   logic [31:0] m_dout;
   int unsigned next_word;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, advance the model, check all outputs.
   task automatic cyc(input logic we, input logic [31:0] d, input logic ack);
      logic acc, grant, exp_valid, exp_start;
      wr_en     = we;
      din       = d;
      burst_ack = ack;
      acc       = we && (mq.size() < DEPTH);
      grant     = ack && burst_req;
      @(posedge clk);
      #1;
      if (acc) mq.push_back(d);
      else if (we) m_ovf = 1'b1;
      if (grant) begin
         exp_valid = 1'b1; exp_start = 1'b1; rem = BURST - 1;
      end else if (rem > 0) begin
         exp_valid = 1'b1; exp_start = 1'b0; rem--;
      end else begin
         exp_valid = 1'b0; exp_start = 1'b0;
      end
      if (exp_valid && mq.size() > 0) m_dout = mq.pop_front();
      chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
      chk("burst_start", 32'(burst_start), 32'(exp_start));
      chk("dout", dout, m_dout);
      chk("level", 32'(level), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - BURST));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (exp_valid) chk("req_during_stream", 32'(burst_req), 32'd0);
      wr_en     = 1'b0;
      burst_ack = 1'b0;
   endtask

   // Random sequential push for the wrap-around run, kept below almost-full.
   task automatic rcyc(input logic ack);
      logic we;
      we = (next_word < 160) && (mq.size() < DEPTH - BURST) && ($urandom_range(0, 3) != 0);
      cyc(we, 32'h1000 + next_word, ack);
      if (we) next_word++;
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      wr_en     = 1'b0;
      burst_ack = 1'b0;
      din       = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      mq.delete();
      m_ovf  = 1'b0;
      rem    = 0;
      m_dout = '0;
      chk("rst_dout", dout, 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_burst_req", 32'(burst_req), 32'd0);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_burst_start", 32'(burst_start), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
   endtask

   task automatic wait_req(input logic rnd);
      for (int k = 0; k < 300 && !burst_req; k++) begin
         if (rnd) rcyc(1'b0);
         else cyc(1'b0, '0, 1'b0);
      end
      chk("req_timeout", 32'(burst_req), 32'd1);
   endtask

   task automatic do_burst();
      wait_req(1'b0);
      cyc(1'b0, '0, 1'b1);
      repeat (BURST) cyc(1'b0, '0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rem = 0;
      m_ovf = 1'b0;
      m_dout = '0;
      next_word = 0;

      // power-up reset
      do_reset(2);

      // random activity, then reset
      for (int i = 0; i < 40; i++)
         cyc(1'($urandom_range(0, 1)), $urandom, burst_req && ($urandom_range(0, 1) == 1));
      do_reset(2);

      // burst threshold and first burst
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, 32'h100 + i, 1'b0);
         chk("req_below_thr", 32'(burst_req), 32'd0);
      end
      repeat (2) begin
         cyc(1'b0, '0, 1'b0);
         chk("req_7_words", 32'(burst_req), 32'd0);
      end
      cyc(1'b1, 32'h107, 1'b0);
      chk("req_n1", 32'(burst_req), 32'd0);
      cyc(1'b0, '0, 1'b0);
      chk("req_n2", 32'(burst_req), 32'd1);
      cyc(1'b0, '0, 1'b1);
      chk("first_beat", dout, 32'h100);
      repeat (BURST) cyc(1'b0, '0, 1'b0);
      chk("last_beat_held", dout, 32'h107);
      chk("level_after_burst", 32'(level), 32'd0);
      cyc(1'b0, '0, 1'b0);
      chk("req_after_burst", 32'(burst_req), 32'd0);

      // full / overflow with no grant
      do_reset(2);
      for (int i = 0; i < 56; i++) cyc(1'b1, 32'h2000 + i, 1'b0);
      chk("af_at_56", 32'(almost_full), 32'd1);
      for (int i = 56; i < 64; i++) cyc(1'b1, 32'h2000 + i, 1'b0);
      chk("full_at_64", 32'(full), 32'd1);
      chk("level_64", 32'(level), 32'd64);
      cyc(1'b1, 32'hDEAD, 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("level_stays_64", 32'(level), 32'd64);
      for (int b = 0; b < 8; b++) do_burst();
      chk("drained_level", 32'(level), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // writes concurrent with streaming
      do_reset(2);
      for (int i = 0; i < 16; i++) cyc(1'b1, 32'h3000 + i, 1'b0);
      wait_req(1'b0);
      cyc(1'b0, '0, 1'b1);
      for (int i = 0; i < BURST; i++) cyc(1'b1, 32'h3010 + i, 1'b0);
      chk("level_concurrent", 32'(level), 32'd16);
      do_burst();
      chk("second_burst_last", dout, 32'h300F);

      // wrap-around with random grant delays
      do_reset(2);
      next_word = 0;
      for (int b = 0; b < 20; b++) begin
         wait_req(1'b1);
         repeat ($urandom_range(0, 5)) rcyc(1'b0);
         rcyc(1'b1);
         repeat (BURST) rcyc(1'b0);
      end
      chk("wrap_words_written", next_word, 32'd160);
      chk("wrap_level", 32'(level), 32'd0);
      chk("wrap_no_ovf", 32'(overflow), 32'd0);
      chk("wrap_last_word", dout, 32'h1000 + 159);

      // reset in the middle of a burst
      do_reset(2);
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'h4000 + i, 1'b0);
      wait_req(1'b0);
      cyc(1'b0, '0, 1'b1);
      repeat (3) cyc(1'b0, '0, 1'b0);
      chk("beat4_word", dout, 32'h4003);
      do_reset(1);
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'h200 + i, 1'b0);
      do_burst();
      chk("fresh_burst_last", dout, 32'h207);
      chk("fresh_level", 32'(level), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
